seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu.sv | 212 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/response handshake bundle for the sequential ALU
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [3:0]       alucontrol;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] aluout;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output in_valid, srca, srcb, alucontrol, out_ready,
        input  in_ready, out_valid, aluout, zero, hi, lo, div_by_zero
    );

    modport slave (
        input  in_valid, srca, srcb, alucontrol, out_ready,
        output in_ready, out_valid, aluout, zero, hi, lo, div_by_zero
    );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - MIPS-style ALU with single-cycle ops and bit-serial multiply/divide
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    seq_alu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] aluout_q, aluout_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    // Request decode: long ops work on operand magnitudes, signs are fixed up at the end
    logic             in_long, in_div, in_signed;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;
    logic [WIDTH-1:0] single_res;

    always_comb begin
        in_long   = bus.alucontrol[3] & ~bus.alucontrol[2];
        in_div    = bus.alucontrol[1];
        in_signed = ~bus.alucontrol[0];
        mag_a_in  = (in_signed && bus.srca[WIDTH-1]) ? (~bus.srca + 1'b1) : bus.srca;
        mag_b_in  = (in_signed && bus.srcb[WIDTH-1]) ? (~bus.srcb + 1'b1) : bus.srcb;
    end

    always_comb begin
        single_res = '0;
        case (bus.alucontrol)
            OP_AND:  single_res = bus.srca & bus.srcb;
            OP_OR:   single_res = bus.srca | bus.srcb;
            OP_ADD:  single_res = bus.srca + bus.srcb;
            OP_SUB:  single_res = bus.srca - bus.srcb;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.srca) < $signed(bus.srcb))};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (bus.srca < bus.srcb)};
            OP_MFHI: single_res = hi_q;
            OP_MFLO: single_res = lo_q;
            default: single_res = '0;
        endcase
    end

    // One iteration of shift-add multiply and restoring divide
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic             rem_fits;
    logic [WIDTH-1:0] div_hi, div_lo;

    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        mul_hi   = mul_sum[WIDTH:1];
        mul_lo   = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, mcand_q};
        rem_fits = ~rem_diff[WIDTH];
        div_hi   = rem_fits ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        div_lo   = {acc_lo_q[WIDTH-2:0], rem_fits};
    end

    logic             a_neg, b_neg, op_div;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_comb begin
        op_div   = op_q[1];
        a_neg    = ~op_q[0] & a_q[WIDTH-1];
        b_neg    = ~op_q[0] & b_q[WIDTH-1];
        prod_fix = {mul_hi, mul_lo};
        if (a_neg ^ b_neg) begin
            prod_fix = ~prod_fix + 1'b1;
        end
        quo_fix = (a_neg ^ b_neg) ? (~div_lo + 1'b1) : div_lo;
        rem_fix = a_neg ? (~div_hi + 1'b1) : div_hi;
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        mcand_d     = mcand_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        count_d     = count_q;
        aluout_d    = aluout_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d = bus.alucontrol;
                    a_d  = bus.srca;
                    b_d  = bus.srcb;
                    if (in_long) begin
                        acc_hi_d = '0;
                        acc_lo_d = in_div ? mag_a_in : mag_b_in;
                        mcand_d  = in_div ? mag_b_in : mag_a_in;
                        count_d  = '0;
                        state_d  = BUSY;
                    end else begin
                        aluout_d    = single_res;
                        dbz_d       = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            BUSY: begin
                acc_hi_d = op_div ? div_hi : mul_hi;
                acc_lo_d = op_div ? div_lo : mul_lo;
                count_d  = count_q + 1'b1;
                if (count_q == CW'(WIDTH-1)) begin
                    if (!op_div) begin
                        hi_d  = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d  = prod_fix[WIDTH-1:0];
                        dbz_d = 1'b0;
                    end else if (b_q == '0) begin
                        hi_d  = a_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d  = rem_fix;
                        lo_d  = quo_fix;
                        dbz_d = 1'b0;
                    end
                    aluout_d    = lo_d;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mcand_q     <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            count_q     <= '0;
            aluout_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mcand_q     <= mcand_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            count_q     <= count_d;
            aluout_q    <= aluout_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.aluout      = aluout_q;
    assign bus.zero        = (aluout_q == '0);
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu against an arithmetic reference model
module tb_seq_alu;
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   rdy_mode = 2;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    exp_t sb[$];

    seq_alu_if #(.WIDTH(32)) bus ();
    seq_alu #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference behaviour from the opcode table using wide integer arithmetic
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int acc, output exp_t e);
        longint sa, sb_v, q, r;
        logic [63:0] p, qv, rv;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        e.alu = '0;
        e.dbz = 1'b0;
        e.lat = 1;
        e.acc = acc;
        case (op)
            OP_AND:  e.alu = a & b;
            OP_OR:   e.alu = a | b;
            OP_ADD:  e.alu = a + b;
            OP_SUB:  e.alu = a - b;
            OP_SLT:  e.alu = (sa < sb_v) ? 32'd1 : 32'd0;
            OP_SLTU: e.alu = (a < b) ? 32'd1 : 32'd0;
            OP_MFHI: e.alu = m_hi;
            OP_MFLO: e.alu = m_lo;
            OP_MULT: begin
                p = sa * sb_v;
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    m_lo = 32'hFFFFFFFF; m_hi = a; e.dbz = 1'b1;
                end else if (op == OP_DIV) begin
                    q = sa / sb_v; r = sa % sb_v;
                    qv = q; rv = r;
                    m_lo = qv[31:0]; m_hi = rv[31:0];
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            default: e.alu = '0;
        endcase
        if (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
            e.alu = m_lo;
            e.lat = 33;
        end
        e.hi = m_hi;
        e.lo = m_lo;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int n = 0;
        while (!bus.in_ready) begin
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.srca       = $urandom;
            bus.srcb       = $urandom;
            bus.alucontrol = 4'($urandom_range(0, 15));
            @(negedge clk);
            n++;
            if (n > 300) begin
                checks++; fails++;
                $display("FAIL in_ready_timeout: got in_ready 0 for %0d cycles required 1 within 300", n);
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid   = 1'b1;
        bus.srca       = a;
        bus.srcb       = b;
        bus.alucontrol = op;
        model(op, a, b, cyc + 1, e);
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !bus.in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; fails++;
            $display("FAIL drain_timeout: got %0d pending results required 0", sb.size());
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready = ($urandom_range(0, 3) != 0);
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops one expectation per presented result, then checks it is held
    initial begin
        exp_t cur;
        bit   active = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 0;
            end else if (bus.out_valid) begin
                if (!active) begin
                    if (sb.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL unexpected_out_valid: got out_valid 1 required 0 at cycle %0d", cyc);
                    end else begin
                        cur = sb.pop_front();
                        chk("aluout", 64'(bus.aluout), 64'(cur.alu));
                        chk("zero", 64'(bus.zero), 64'(cur.alu == 0));
                        chk("hi", 64'(bus.hi), 64'(cur.hi));
                        chk("lo", 64'(bus.lo), 64'(cur.lo));
                        chk("div_by_zero", 64'(bus.div_by_zero), 64'(cur.dbz));
                        chk("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
                        active = 1;
                    end
                end else begin
                    chk("hold_aluout", 64'(bus.aluout), 64'(cur.alu));
                    chk("hold_div_by_zero", 64'(bus.div_by_zero), 64'(cur.dbz));
                    chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
                end
                if (bus.out_ready) active = 0;
            end
        end
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.srca       = '0;
        bus.srcb       = '0;
        bus.alucontrol = '0;
        bus.out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(bus.in_ready), 64'(1));
        chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
        chk("reset_aluout", 64'(bus.aluout), 64'(0));
        chk("reset_hilo", {bus.hi, bus.lo}, 64'(0));
        chk("reset_dbz", 64'(bus.div_by_zero), 64'(0));
        reset = 1'b0;

        send(OP_SUB, 32'd5, 32'd5);
        send(OP_SLT, 32'h80000000, 32'h1);
        send(OP_SLTU, 32'h80000000, 32'h1);
        send(OP_MULT, 32'hFFFFFFFF, 32'h2);
        drain();
        chk("mult_hi_const", 64'(bus.hi), 64'hFFFFFFFF);
        chk("mult_lo_const", 64'(bus.lo), 64'hFFFFFFFE);
        send(OP_MULTU, 32'hFFFFFFFF, 32'h2);
        drain();
        chk("multu_hi_const", 64'(bus.hi), 64'h1);
        send(OP_MFHI, 32'h0, 32'h0);
        send(OP_MFLO, 32'h0, 32'h0);
        send(OP_DIV, 32'hFFFFFFF9, 32'h2);
        drain();
        chk("div_lo_const", 64'(bus.lo), 64'hFFFFFFFD);
        chk("div_hi_const", 64'(bus.hi), 64'hFFFFFFFF);
        send(OP_DIVU, 32'd7, 32'd0);
        drain();
        chk("divu0_lo_const", 64'(bus.lo), 64'hFFFFFFFF);
        chk("divu0_hi_const", 64'(bus.hi), 64'd7);
        send(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        send(OP_MFHI, 32'h0, 32'h0);
        send(4'b1111, 32'h1234, 32'h5678);
        drain();

        rdy_mode = 1;
        send(OP_ADD, $urandom, $urandom);
        repeat (5) @(negedge clk);
        rdy_mode = 2;
        @(posedge clk);
        #3;
        chk("stall_out_valid", 64'(bus.out_valid), 64'(1));
        @(posedge clk);
        #1;
        chk("release_in_ready", 64'(bus.in_ready), 64'(1));
        chk("release_out_valid", 64'(bus.out_valid), 64'(0));
        @(negedge clk);

        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            send(4'($urandom_range(0, 15)), rnd_val(), rnd_val());
            if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        rdy_mode = 2;
        send(OP_MULTU, 32'h12345678, 32'h9ABCDEF0);
        drain();
        send(OP_DIVU, $urandom, $urandom | 32'h1);
        repeat (9) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_in_ready", 64'(bus.in_ready), 64'(1));
        chk("abort_out_valid", 64'(bus.out_valid), 64'(0));
        chk("abort_hilo", {bus.hi, bus.lo}, 64'(0));
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        send(OP_ADD, 32'd1, 32'd2);
        drain();
        chk("post_reset_add", 64'(bus.aluout), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
